// File: rtl/mem_arb_pkg.sv
// Purpose: shared constants for the two-port BRAM arbiter (FSM encoding, rw codes).
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Transaction FSM encoding, kept as plain 2-bit constants for legacy tools
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Request direction on req_rw / mem_rw
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Purpose: bundles both requester channels and the BRAM pins of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req valid/ready and rsp valid/ready per port; BRAM side has none.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_arb_pkg::*;

    // Port 0: instruction fetch
    logic              p0_req_valid;
    logic              p0_req_ready;
    logic              p0_req_rw;
    logic [ADDR_W-1:0] p0_req_addr;
    logic [DATA_W-1:0] p0_req_wdata;
    logic              p0_rsp_valid;
    logic              p0_rsp_ready;
    logic [DATA_W-1:0] p0_rsp_rdata;

    // Port 1: data load/store or loader/DMA
    logic              p1_req_valid;
    logic              p1_req_ready;
    logic              p1_req_rw;
    logic [ADDR_W-1:0] p1_req_addr;
    logic [DATA_W-1:0] p1_req_wdata;
    logic              p1_rsp_valid;
    logic              p1_rsp_ready;
    logic [DATA_W-1:0] p1_rsp_rdata;

    // Single BRAM port
    logic              mem_enable;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side: serves requests and drives the BRAM
    modport slave (
        input  p0_req_valid, p0_req_rw, p0_req_addr, p0_req_wdata, p0_rsp_ready,
        input  p1_req_valid, p1_req_rw, p1_req_addr, p1_req_wdata, p1_rsp_ready,
        input  mem_rdata,
        output p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
        output p1_req_ready, p1_rsp_valid, p1_rsp_rdata,
        output mem_enable, mem_rw, mem_addr, mem_wdata
    );

    // Requester/memory side
    modport master (
        output p0_req_valid, p0_req_rw, p0_req_addr, p0_req_wdata, p0_rsp_ready,
        output p1_req_valid, p1_req_rw, p1_req_addr, p1_req_wdata, p1_rsp_ready,
        output mem_rdata,
        input  p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
        input  p1_req_ready, p1_rsp_valid, p1_rsp_rdata,
        input  mem_enable, mem_rw, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Purpose: two-input round-robin select; on a tie the port that did not win last time wins.
// Latency: combinational.
// Backpressure: none; caller qualifies sel_o with any_o.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       sel_o,
    output logic       any_o
);

    // Lone requester wins outright; a tie goes to the port opposite last_grant
    always_comb begin
        any_o = |valid_i;
        if (&valid_i) begin
            sel_o = ~last_grant_i;
        end else begin
            sel_o = valid_i[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares one BRAM port between two requesters, one transaction at a time, round-robin.
// Latency: write rsp 2 cycles after accept, read rsp READ_LATENCY+2 cycles after accept.
// Backpressure: req_ready only in IDLE; RESP holds until the granted port's rsp_ready.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output logic          busy,
    output logic          grant
);

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    // A zero-latency BRAM would make the WAIT countdown meaningless
    generate
        if (READ_LATENCY < 1) begin : g_bad_latency
            $error("mem_arbiter: READ_LATENCY must be at least 1");
        end
    endgenerate

    logic [1:0]        state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              sel;
    logic              any;
    logic              in_idle;
    logic              rsp_ready_sel;

    rr_arb2 u_rr (
        .valid_i      ({bus.p1_req_valid, bus.p0_req_valid}),
        .last_grant_i (last_grant_q),
        .sel_o        (sel),
        .any_o        (any)
    );

    assign in_idle       = (state_q == ST_IDLE);
    assign rsp_ready_sel = grant_q ? bus.p1_rsp_ready : bus.p0_rsp_ready;

    assign bus.p0_req_ready = in_idle & any & ~sel;
    assign bus.p1_req_ready = in_idle & any &  sel;

    assign bus.p0_rsp_valid = (state_q == ST_RESP) & ~grant_q;
    assign bus.p1_rsp_valid = (state_q == ST_RESP) &  grant_q;
    assign bus.p0_rsp_rdata = rdata_q;
    assign bus.p1_rsp_rdata = rdata_q;

    // BRAM pins come straight from the latched request; only mem_enable qualifies them
    assign bus.mem_enable = (state_q == ST_ISSUE);
    assign bus.mem_rw     = rw_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;

    assign busy  = ~in_idle;
    assign grant = grant_q;

    // Next-state: accept in IDLE, pulse BRAM in ISSUE, count out read latency, hold response
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    rw_d         = sel ? bus.p1_req_rw    : bus.p0_req_rw;
                    addr_d       = sel ? bus.p1_req_addr  : bus.p0_req_addr;
                    wdata_d      = sel ? bus.p1_req_wdata : bus.p0_req_wdata;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (rw_q == RW_WRITE) begin
                    rdata_d = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = bus.mem_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_sel) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rw_q         <= RW_READ;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule
